// File: rtl/rgb2yuv_core.sv
// rtl/rgb2yuv_core.sv - buffered RGB to YUV/YCbCr converter with two-stage pipeline
// Input pixels are loaded through WrEn, converted on Start, and read back via RdAddr.
module rgb2yuv_core #(
   parameter int PIX_W = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Start,
   input  logic [AW:0]          Len,
   input  logic                 Mode,
   input  logic                 WrEn,
   input  logic [AW-1:0]        WrAddr,
   input  logic [3*PIX_W-1:0]   WrData,
   input  logic [AW-1:0]        RdAddr,
   output logic [3*PIX_W-1:0]   RdData,
   output logic                 Busy,
   output logic                 Finish
);

   localparam int LW = AW + 1;
   // Wide enough for both the minimum product width and the full 3-term sum.
   localparam int PW = (2*PIX_W + 2 > PIX_W + 10) ? 2*PIX_W + 2 : PIX_W + 10;

   localparam logic signed [PW-1:0] C_YR = PW'(77);
   localparam logic signed [PW-1:0] C_YG = PW'(150);
   localparam logic signed [PW-1:0] C_YB = PW'(29);
   localparam logic signed [PW-1:0] C_UR = PW'(-43);
   localparam logic signed [PW-1:0] C_UG = PW'(-85);
   localparam logic signed [PW-1:0] C_UB = PW'(128);
   localparam logic signed [PW-1:0] C_VR = PW'(128);
   localparam logic signed [PW-1:0] C_VG = PW'(-107);
   localparam logic signed [PW-1:0] C_VB = PW'(-21);

   localparam logic signed [PW-1:0] ZERO = '0;
   localparam logic signed [PW-1:0] UMAX = PW'((1 << PIX_W) - 1);
   localparam logic signed [PW-1:0] SMAX = PW'((1 << (PIX_W - 1)) - 1);
   localparam logic signed [PW-1:0] SMIN = PW'(-(1 << (PIX_W - 1)));
   localparam logic signed [PW-1:0] HALF = PW'(1 << (PIX_W - 1));

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [LW-1:0]         len_q, len_d, cnt_q, cnt_d, len_eff;
   logic                  mode_q, mode_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [AW-1:0]         s1_idx_q, s1_idx_d;
   logic signed [PW-1:0]  prod_q [9];
   logic signed [PW-1:0]  prod_d [9];
   logic [3*PIX_W-1:0]    in_mem_q  [DEPTH];
   logic [3*PIX_W-1:0]    out_mem_q [DEPTH];

   logic [3*PIX_W-1:0]    pix;
   logic signed [PW-1:0]  r_ext, g_ext, b_ext;
   logic signed [PW-1:0]  y_sum, u_sum, v_sum, y_sh, u_sh, v_sh;
   logic signed [PW-1:0]  lo_c, hi_c, off_c;
   logic [PIX_W-1:0]      y_res, u_res, v_res;

   function automatic logic [PIX_W-1:0] sat(input logic signed [PW-1:0] val,
                                             input logic signed [PW-1:0] lo,
                                             input logic signed [PW-1:0] hi);
      logic signed [PW-1:0] t;
      if (val < lo)      t = lo;
      else if (val > hi) t = hi;
      else               t = val;
      return PIX_W'(t);
   endfunction

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      len_eff = (Len > LW'(DEPTH)) ? LW'(DEPTH) : Len;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (Start) begin
               len_d   = len_eff;
               mode_d  = Mode;
               cnt_d   = '0;
               state_d = (len_eff == '0) ? S_DONE : S_CONV;
            end
         end
         S_CONV: begin
            cnt_d = cnt_q + 1'b1;
            // Counter reaches len one cycle after the last read, while that pixel drains.
            if (cnt_q == len_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pix        = in_mem_q[cnt_q[AW-1:0]];
      s1_valid_d = (state_q == S_CONV) && (cnt_q < len_q);
      s1_idx_d   = cnt_q[AW-1:0];
      r_ext      = PW'(pix[3*PIX_W-1 -: PIX_W]);
      g_ext      = PW'(pix[2*PIX_W-1 -: PIX_W]);
      b_ext      = PW'(pix[PIX_W-1:0]);
      prod_d[0]  = r_ext * C_YR;
      prod_d[1]  = g_ext * C_YG;
      prod_d[2]  = b_ext * C_YB;
      prod_d[3]  = r_ext * C_UR;
      prod_d[4]  = g_ext * C_UG;
      prod_d[5]  = b_ext * C_UB;
      prod_d[6]  = r_ext * C_VR;
      prod_d[7]  = g_ext * C_VG;
      prod_d[8]  = b_ext * C_VB;
   end

   always_comb begin
      y_sum = prod_q[0] + prod_q[1] + prod_q[2];
      u_sum = prod_q[3] + prod_q[4] + prod_q[5];
      v_sum = prod_q[6] + prod_q[7] + prod_q[8];
      y_sh  = y_sum >>> 8;
      u_sh  = u_sum >>> 8;
      v_sh  = v_sum >>> 8;
      lo_c  = mode_q ? ZERO : SMIN;
      hi_c  = mode_q ? UMAX : SMAX;
      off_c = mode_q ? HALF : ZERO;
      y_res = sat(y_sh, ZERO, UMAX);
      u_res = sat(u_sh + off_c, lo_c, hi_c);
      v_res = sat(v_sh + off_c, lo_c, hi_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         for (int i = 0; i < 9; i++) prod_q[i] <= '0;
         for (int i = 0; i < DEPTH; i++) out_mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         prod_q     <= prod_d;
         if (s1_valid_q) out_mem_q[s1_idx_q] <= {y_res, u_res, v_res};
      end
   end

   // Input buffer is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && WrEn && (state_q != S_CONV)) in_mem_q[WrAddr] <= WrData;
   end

   assign RdData = out_mem_q[RdAddr];
   assign Busy   = (state_q == S_CONV);
   assign Finish = (state_q == S_DONE);

endmodule
